// File: rtl/wb_ram_slave_if.sv
// Wishbone B4 classic bus bundle shared by a master and the RAM responder.
interface wb_ram_slave_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack;
  logic        err;

  modport master (
    output cyc, stb, we, adr, sel, dat_i,
    input  dat_o, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_i,
    output dat_o, ack, err
  );
endinterface

// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic responder in front of a word-organised synchronous RAM.
// Decodes an address window, honours byte selects on writes, inserts a fixed
// number of wait states and terminates every strobed cycle with one ack or err.
module wb_ram_slave #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic         clk,
  input  logic         rst,
  wb_ram_slave_if.slave bus
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) * 33'd4;
  localparam bit          NO_WAIT   = (WAIT_STATES == 0);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [3:0]       cnt_r;
  logic [IDX_W-1:0] idx_r;
  logic             we_r;
  logic [3:0]       sel_r;
  logic [31:0]      wdat_r;

  logic [31:0]      off_s;
  logic             in_range_s;
  logic             req_s;
  logic [IDX_W-1:0] acc_idx_s;
  logic             acc_we_s;
  logic [3:0]       acc_sel_s;
  logic [31:0]      acc_dat_s;
  logic             commit_s;

  logic [31:0]      mem_r [DEPTH_WORDS];
  logic             ack_r;
  logic             err_r;
  logic [31:0]      dat_o_r;

  // Address decode: offset into the window and an unsigned range test (wraps below base).
  always_comb begin
    off_s      = bus.adr - BASE_ADDR;
    in_range_s = ({1'b0, off_s} < SPAN);
    req_s      = bus.cyc & bus.stb;
  end

  // Next-state logic; a dropped cyc during the wait window abandons the request.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (!in_range_s) begin
            next_state_s = ERR;
          end else if (NO_WAIT) begin
            next_state_s = RESP;
          end else begin
            next_state_s = WAIT;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        if (!bus.cyc) begin
          next_state_s = IDLE;
        end else if (cnt_r == 4'd0) begin
          next_state_s = RESP;
        end else begin
          next_state_s = WAIT;
        end
      end
      RESP:    next_state_s = IDLE;
      ERR:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // RAM access operands: live bus when committing straight from IDLE, latched request otherwise.
  always_comb begin
    if (state_r == IDLE) begin
      acc_idx_s = off_s[IDX_W+1:2];
      acc_we_s  = bus.we;
      acc_sel_s = bus.sel;
      acc_dat_s = bus.dat_i;
    end else begin
      acc_idx_s = idx_r;
      acc_we_s  = we_r;
      acc_sel_s = sel_r;
      acc_dat_s = wdat_r;
    end
    commit_s = !rst && (next_state_s == RESP);
  end

  // State register, request capture and wait-state counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      idx_r   <= '0;
      we_r    <= 1'b0;
      sel_r   <= 4'd0;
      wdat_r  <= 32'd0;
    end else begin
      state_r <= next_state_s;
      if ((state_r == IDLE) && req_s) begin
        idx_r  <= off_s[IDX_W+1:2];
        we_r   <= bus.we;
        sel_r  <= bus.sel;
        wdat_r <= bus.dat_i;
      end
      if ((state_r == IDLE) && (next_state_s == WAIT)) begin
        cnt_r <= WAIT_LOAD;
      end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
    end
  end

  // RAM write port: only lanes with their select bit set are updated.
  always_ff @(posedge clk) begin
    if (commit_s && acc_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_sel_s[i]) begin
          mem_r[acc_idx_s][8*i +: 8] <= acc_dat_s[8*i +: 8];
        end
      end
    end
  end

  // Registered termination pulses and read data; dat_o only moves on read commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      dat_o_r <= 32'd0;
    end else begin
      ack_r <= (next_state_s == RESP);
      err_r <= (next_state_s == ERR);
      if (commit_s && !acc_we_s) begin
        dat_o_r <= mem_r[acc_idx_s];
      end
    end
  end

  assign bus.ack   = ack_r;
  assign bus.err   = err_r;
  assign bus.dat_o = dat_o_r;

endmodule
